buffer_loader: RTL
==================

# buffer_loader

Upstream feeder for the data buffer shift register. Collects 8-bit bytes from the UART receiver, packs them MSB-first into WORDWIDTH-bit words, and presents each completed word on `dataOut` with a one-cycle `enable` pulse that shifts it into the buffer. A load is framed: `start` arms it, LENGTH words complete it, and a receive-gap timeout aborts it.

## Interface
- `WORDWIDTH`, 24: word width in bits; must be a multiple of 8 and ≥ 8. BYTES = WORDWIDTH/8.
- `LENGTH`, 16: words per frame; matches the buffer depth; ≥ 1.
- `TIMEOUT`, 100000: maximum idle cycles between bytes inside a frame; ≥ 2.

- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `rxData`  in  8  received byte; valid only when `rxReady`=1.
- `rxReady`  in  1  one-cycle strobe, one byte per strobe.
- `start`  in  1  arms a new frame load (level sampled per cycle).
- `dataOut`  out  WORDWIDTH  assembled word; connects to buffer `dataIn`.
- `enable`  out  1  one-cycle shift strobe; connects to buffer `enable`.
- `busy`  out  1  high while in RECV.
- `frameDone`  out  1  one-cycle pulse after the LENGTH-th word.
- `error`  out  1  sticky timeout flag; cleared by `start` or `rst`.

## Operation
- States: IDLE, RECV, DONE, ERROR. Reset → IDLE.
- IDLE: `rxReady` ignored. On `start`=1, clear byteCnt, wordCnt, gapCnt, and the shift accumulator; clear `error`; go to RECV. If `start` and `rxReady` arrive in the same cycle, `start` wins and the byte is dropped.
- RECV: `busy`=1; `start` ignored.
  - On `rxReady`: set acc <= {acc[WORDWIDTH-9:0], rxData}; gapCnt <= 0; byteCnt++.
  - When byteCnt = BYTES-1 and `rxReady`=1, the word is complete. On that edge: `dataOut` <= {acc[WORDWIDTH-9:0], rxData}, `enable` <= 1, byteCnt <= 0, wordCnt++.
  - If that word is the LENGTH-th, go to DONE on the same edge.
  - With no `rxReady`, gapCnt++. When gapCnt reaches TIMEOUT-1 and no `rxReady` arrives, go to ERROR. The partial word is discarded and no `enable` is issued.
- DONE: `frameDone`=1 for exactly one cycle, then IDLE. Bytes arriving in DONE are dropped.
- ERROR: `error` set. Next cycle go to IDLE; `error` stays high in IDLE until the next `start`.
- Counter widths: byteCnt ≥ $clog2(BYTES) bits; wordCnt ≥ $clog2(LENGTH+1) bits; gapCnt ≥ $clog2(TIMEOUT) bits. Counters never wrap in legal operation.
- WORDWIDTH=8: every accepted byte is a full word.

## Timing
- All outputs registered. Reset values: `dataOut`=0, `enable`=0, `busy`=0, `frameDone`=0, `error`=0.
- `enable` is high in the cycle after the final `rxReady` of a word. `dataOut` updates on that same edge and holds until the next word.
- `frameDone` is high in the cycle after the last `enable`; `busy` falls on the same edge.
- `busy` rises the cycle after `start` is sampled in IDLE.
- Back-to-back `rxReady` on consecutive cycles must be accepted with no loss.
- `rst` mid-frame: immediate return to IDLE with all outputs at reset values. The buffer contents are not touched.
- Timeout: `error` rises TIMEOUT cycles after the last accepted byte, or after entering RECV if no byte has arrived.

## Test plan
- **Basic frame** (WORDWIDTH=24, LENGTH=4): `start`, then 12 bytes 0x01..0x0C, one every 5 cycles. Expect `enable` 4 times with `dataOut` = 0x010203, 0x040506, 0x070809, 0x0A0B0C. Expect one `frameDone` the cycle after the 4th `enable`, and `busy` low after it.
- **Back-to-back bytes**: 12 consecutive-cycle `rxReady` pulses. Expect identical words, with `enable` on cycles 4, 7, 10, 13 counted from the first byte (cycle 1).
- **Timeout** (TIMEOUT=50): `start`, then 4 bytes, then silence. Expect exactly one `enable` (word 0x010203). Expect `error`=1 50 cycles after byte 4, then IDLE. A new `start` clears `error`.
- **Ignored inputs**: bytes in IDLE, `start` during RECV, and `start`+`rxReady` in the same cycle in IDLE. Expect no `enable`, no counter disturbance, and the simultaneous byte dropped.
- **Reset mid-frame**: assert `rst` after 7 bytes. Expect all outputs 0 immediately. After release and a new `start`, 12 bytes yield clean words starting at the first new byte.
- **WORDWIDTH=8, LENGTH=1**: `start`, then byte 0xA5. Expect `enable` with `dataOut`=0xA5, then `frameDone` next cycle.

Source files
------------

// File: rtl/buffer_loader.sv
// buffer_loader: packs UART bytes MSB-first into words and strobes them into the data buffer, framed by start/length/timeout.
module buffer_loader #(
  parameter int WORDWIDTH = 24,
  parameter int LENGTH    = 16,
  parameter int TIMEOUT   = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rxData,
  input  logic                 rxReady,
  input  logic                 start,
  output logic [WORDWIDTH-1:0] dataOut,
  output logic                 enable,
  output logic                 busy,
  output logic                 frameDone,
  output logic                 error
);
  localparam int BYTES = WORDWIDTH / 8;
  localparam int BW    = BYTES > 1 ? $clog2(BYTES) : 1;
  localparam int WCW   = $clog2(LENGTH + 1);
  localparam int GW    = $clog2(TIMEOUT);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] ERROR = 2'd3;
  localparam logic [BW-1:0]  LAST_BYTE = BW'(BYTES - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(LENGTH - 1);
  localparam logic [GW-1:0]  LAST_GAP  = GW'(TIMEOUT - 1);

  logic [1:0]           state_q, state_d;
  logic [BW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [WCW-1:0]       word_cnt_q, word_cnt_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [WORDWIDTH-1:0] acc_q, acc_d;
  logic [WORDWIDTH-1:0] data_q, data_d;
  logic                 enable_q, enable_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [WORDWIDTH-1:0] word;

  // shifting rather than slicing keeps the 8-bit word case legal
  assign word = (acc_q << 8) | WORDWIDTH'(rxData);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    acc_d      = acc_q;
    data_d     = data_q;
    enable_d   = 1'b0;
    done_d     = 1'b0;
    error_d    = error_q;
    case (state_q)
      IDLE: if (start) begin
        state_d    = RECV;
        byte_cnt_d = '0;
        word_cnt_d = '0;
        gap_cnt_d  = '0;
        acc_d      = '0;
        error_d    = 1'b0;
      end
      RECV: if (rxReady) begin
        acc_d      = word;
        gap_cnt_d  = '0;
        byte_cnt_d = byte_cnt_q + 1'b1;
        if (byte_cnt_q == LAST_BYTE) begin
          byte_cnt_d = '0;
          data_d     = word;
          enable_d   = 1'b1;
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = word_cnt_q == LAST_WORD ? DONE : RECV;
        end
      end else if (gap_cnt_q == LAST_GAP) begin
        state_d = ERROR;
        error_d = 1'b1;
      end else begin
        gap_cnt_d = gap_cnt_q + 1'b1;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // busy holds through DONE so it falls on the same edge frameDone rises
    busy_d = state_d == RECV || state_d == DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      gap_cnt_q  <= '0;
      acc_q      <= '0;
      data_q     <= '0;
      enable_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      acc_q      <= acc_d;
      data_q     <= data_d;
      enable_q   <= enable_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign dataOut   = data_q;
  assign enable    = enable_q;
  assign busy      = busy_q;
  assign frameDone = done_q;
  assign error     = error_q;
endmodule
